// File: rtl/ccff_config_loader.sv
// Configuration-chain loader: takes framed config words over valid/ready, serializes them
// LSB first into a shift chain, and commits the chain atomically to the mem_out/mem_outb selects.
module ccff_config_loader #(
   parameter int CHAIN_LEN = 32,
   parameter int WORD_W    = 8
) (
   input  logic                 prog_clk,
   input  logic                 prog_rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [WORD_W-1:0]    cfg_data,
   input  logic                 cfg_last,
   output logic [CHAIN_LEN-1:0] mem_out,
   output logic [CHAIN_LEN-1:0] mem_outb,
   output logic                 ccff_tail,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int SC_W  = $clog2(WORD_W);
   localparam logic [SC_W-1:0]  SH_LAST  = SC_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_WAIT, S_SHIFT, S_COMMIT, S_DONE, S_ERR
   } state_t;

   state_t                state_q,   state_d;
   logic [CHAIN_LEN-1:0]  sr_q,      sr_d;
   logic [CHAIN_LEN-1:0]  mem_q,     mem_d;
   logic [WORD_W-1:0]     word_q,    word_d;
   logic                  last_q,    last_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [SC_W-1:0]       sh_cnt_q,  sh_cnt_d;
   logic                  full;

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q   <= S_IDLE;
         sr_q      <= '0;
         mem_q     <= '0;
         word_q    <= '0;
         last_q    <= 1'b0;
         bit_cnt_q <= '0;
         sh_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         mem_q     <= mem_d;
         word_q    <= word_d;
         last_q    <= last_d;
         bit_cnt_q <= bit_cnt_d;
         sh_cnt_q  <= sh_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      mem_d     = mem_q;
      word_d    = word_q;
      last_d    = last_q;
      bit_cnt_d = bit_cnt_q;
      sh_cnt_d  = sh_cnt_q;
      full      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d   = S_LOAD_WAIT;
               sr_d      = '0;
               bit_cnt_d = '0;
               last_d    = 1'b0;
            end
         end
         S_LOAD_WAIT: begin
            if (cfg_valid) begin
               word_d   = cfg_data;
               last_d   = cfg_last;
               sh_cnt_d = '0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_d      = {sr_q[CHAIN_LEN-2:0], word_q[0]};
            word_d    = word_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            sh_cnt_d  = sh_cnt_q + 1'b1;
            // Framing is judged only on word boundaries, so bit_cnt can never pass CHAIN_LEN.
            if (sh_cnt_q == SH_LAST) begin
               full = (bit_cnt_q == CNT_LAST);
               if (full && last_q)      state_d = S_COMMIT;
               else if (full ^ last_q)  state_d = S_ERR;
               else                     state_d = S_LOAD_WAIT;
            end
         end
         S_COMMIT: begin
            mem_d   = sr_q;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort discards the partial chain but leaves the committed selects alone.
      if (abort) begin
         state_d   = S_IDLE;
         sr_d      = '0;
         bit_cnt_d = '0;
         last_d    = 1'b0;
         sh_cnt_d  = '0;
         mem_d     = mem_q;
      end
   end

   assign cfg_ready = (state_q == S_LOAD_WAIT);
   assign busy      = (state_q == S_LOAD_WAIT) || (state_q == S_SHIFT) || (state_q == S_COMMIT);
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERR);
   assign mem_out   = mem_q;
   assign mem_outb  = ~mem_q;
   assign ccff_tail = sr_q[CHAIN_LEN-1];

endmodule

// File: tb/tb_ccff_config_loader.sv
// Scoreboard bench for ccff_config_loader (CHAIN_LEN=16, WORD_W=8): directed sessions push the
// expected commit/error outcome, a monitor checks it whenever done or error rises.
module tb_ccff_config_loader;

   localparam int CL = 16;
   localparam int WW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0;
   logic [WW-1:0] cfg_data = '0;
   logic          cfg_ready, ccff_tail, busy, done, error;
   logic [CL-1:0] mem_out, mem_outb;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic          is_err;
      logic [CL-1:0] mem;
   } exp_t;
   exp_t sb[$];

   ccff_config_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .abort(abort),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
      .mem_out(mem_out), .mem_outb(mem_outb), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare against the scoreboard on every rising done/error.
   logic done_p = 1'b0, err_p = 1'b0;
   always @(negedge clk) begin
      if (rst_n && ((done && !done_p) || (error && !err_p))) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_unexpected: done=%0b error=%0b mem_out=%0h with nothing expected",
                     done, error, mem_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_error", {31'd0, error}, {31'd0, e.is_err});
            check("sb_done",  {31'd0, done},  {31'd0, ~e.is_err});
            check("sb_mem",   {16'd0, mem_out},  {16'd0, e.mem});
            check("sb_memb",  {16'd0, mem_outb}, {16'd0, ~e.mem});
         end
      end
      done_p <= done;
      err_p  <= error;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [WW-1:0] d, input logic l, input int bound,
                            output bit acc);
      int i;
      i = 0;
      acc = 1'b0;
      cfg_data  = d;
      cfg_last  = l;
      cfg_valid = 1'b1;
      while (!cfg_ready && i < bound) begin
         tick();
         i++;
      end
      if (cfg_ready) begin
         tick();
         acc = 1'b1;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!cfg_ready && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_flag(output int n);
      n = 0;
      while (!(done || error) && n < 50) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [WW-1:0] rev(input logic [WW-1:0] w);
      for (int i = 0; i < WW; i++) rev[i] = w[WW-1-i];
   endfunction

   task automatic push(input logic is_err, input logic [CL-1:0] m);
      exp_t e;
      e.is_err = is_err;
      e.mem    = m;
      sb.push_back(e);
   endtask

   initial begin
      bit acc;
      int n;
      logic [WW-1:0] w0, w1;

      // Reset values
      #12;
      check("rst_mem",   {16'd0, mem_out},  32'h0000);
      check("rst_memb",  {16'd0, mem_outb}, 32'hFFFF);
      check("rst_ready", {31'd0, cfg_ready}, 0);
      check("rst_done",  {31'd0, done}, 0);
      check("rst_error", {31'd0, error}, 0);
      check("rst_busy",  {31'd0, busy}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Normal load A5, 3C
      do_start();
      check("start_ready", {31'd0, cfg_ready}, 1);
      check("start_busy",  {31'd0, busy}, 1);
      send_word(8'hA5, 1'b0, 20, acc);
      check("acc_w0", {31'd0, acc}, 1);
      check("shift_ready_low", {31'd0, cfg_ready}, 0);
      wait_ready(n);
      check("ready_gap", n, 8);
      push(1'b0, 16'hA53C);
      send_word(8'h3C, 1'b1, 20, acc);
      check("acc_w1", {31'd0, acc}, 1);
      wait_flag(n);
      check("done_latency", n, 9);
      check("norm_mem",  {16'd0, mem_out},  32'hA53C);
      check("norm_memb", {16'd0, mem_outb}, 32'h5AC3);
      check("norm_tail", {31'd0, ccff_tail}, 1);
      check("norm_busy", {31'd0, busy}, 0);

      // Bit order
      do_start();
      push(1'b0, 16'h8000);
      send_word(8'h01, 1'b0, 20, acc);
      send_word(8'h00, 1'b1, 20, acc);
      wait_flag(n);
      tick();

      // Framing: early last
      do_start();
      push(1'b1, 16'h8000);
      send_word(8'hFF, 1'b1, 20, acc);
      wait_flag(n);
      check("early_last_err", {31'd0, error}, 1);
      tick();

      // Framing: missing last, third word must not be taken
      do_start();
      send_word(8'h11, 1'b0, 20, acc);
      push(1'b1, 16'h8000);
      send_word(8'h22, 1'b0, 20, acc);
      wait_flag(n);
      check("nolast_err", {31'd0, error}, 1);
      send_word(8'h33, 1'b0, 12, acc);
      check("no_xfer_in_err", {31'd0, acc}, 0);
      check("err_held", {31'd0, error}, 1);

      // Recovery: valid session after error
      do_start();
      check("restart_err_clr", {31'd0, error}, 0);
      push(1'b0, 16'h482C);
      send_word(8'h12, 1'b0, 20, acc);
      send_word(8'h34, 1'b1, 20, acc);
      wait_flag(n);
      check("recov_done",  {31'd0, done}, 1);
      check("recov_error", {31'd0, error}, 0);
      tick();

      // Abort mid-SHIFT
      do_start();
      send_word(8'h77, 1'b1, 20, acc);
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy",  {31'd0, busy}, 0);
      check("abort_ready", {31'd0, cfg_ready}, 0);
      check("abort_done",  {31'd0, done}, 0);
      check("abort_mem",   {16'd0, mem_out}, 32'h482C);
      check("abort_tail",  {31'd0, ccff_tail}, 0);
      repeat (12) tick();
      check("abort_stays_idle", {31'd0, busy | done | error}, 0);

      // Async reset mid-SHIFT
      do_start();
      send_word(8'hC3, 1'b0, 20, acc);
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      check("areset_mem",   {16'd0, mem_out},  32'h0000);
      check("areset_memb",  {16'd0, mem_outb}, 32'hFFFF);
      check("areset_busy",  {31'd0, busy}, 0);
      check("areset_ready", {31'd0, cfg_ready}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Handshake stress: random gaps, start pulses while busy
      for (int s = 0; s < 5; s++) begin
         do_start();
         w0 = 8'($urandom);
         w1 = 8'($urandom);
         for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 10)) begin
               start = ($urandom_range(0, 2) == 0);
               tick();
               start = 1'b0;
            end
            if (k == 1) push(1'b0, {rev(w0), rev(w1)});
            send_word((k == 0) ? w0 : w1, k == 1, 40, acc);
            check("stress_acc", {31'd0, acc}, 1);
         end
         wait_flag(n);
         check("stress_done", {31'd0, done}, 1);
         tick();
      end

      repeat (3) tick();
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
